// File: rtl/insn_prefetch_queue_if.sv
// Instruction prefetch queue bus bundle.
// Groups the instruction-memory request channel and the decoder-facing queue
// head into a single interface.
//   master : the prefetch queue (drives the memory request and the queue head)
//   slave  : the environment (memory model and decoder)
// Signals:
//   imem_req_o / imem_addr_o   : read request and word address
//   imem_ack_i / imem_data_i   : request accepted, data returned in the same cycle
//   valid_o / insn_o / pc_o    : queue head
//   stall_i                    : decoder back-pressure
//   redirect_i / redirect_pc_i : flush and restart fetch at a new address
interface insn_prefetch_queue_if #(
  parameter int LEN_INSN = 32,
  parameter int LEN_ADDR = 16
);
  logic                imem_req_o;
  logic [LEN_ADDR-1:0] imem_addr_o;
  logic                imem_ack_i;
  logic [LEN_INSN-1:0] imem_data_i;
  logic                valid_o;
  logic [LEN_INSN-1:0] insn_o;
  logic [LEN_ADDR-1:0] pc_o;
  logic                stall_i;
  logic                redirect_i;
  logic [LEN_ADDR-1:0] redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, insn_o, pc_o,
    input  imem_ack_i, imem_data_i, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, insn_o, pc_o,
    output imem_ack_i, imem_data_i, stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/insn_prefetch_queue.sv
// Instruction prefetch queue.
// Fetches sequential instruction words from a single-outstanding-request
// memory into a DEPTH-entry circular FIFO of {pc, insn}. The decoder pops the
// head whenever valid_o=1 and stall_i=0. A redirect flushes the queue and
// restarts fetch at redirect_pc_i; a request that is still in flight at that
// moment is tracked in DROP so its late data is thrown away.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : insn_prefetch_queue_if.master (memory request channel + queue head)
module insn_prefetch_queue #(
  parameter int                  LEN_INSN = 32,
  parameter int                  LEN_ADDR = 16,
  parameter int                  DEPTH    = 4,   // power of two, >= 2
  parameter logic [LEN_ADDR-1:0] RESET_PC = '0
) (
  input logic                   clk,
  input logic                   rst,
  insn_prefetch_queue_if.master bus
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  typedef struct packed {
    logic [LEN_ADDR-1:0] pc;
    logic [LEN_INSN-1:0] insn;
  } entry_t;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [LEN_ADDR-1:0] addr_q, addr_d;
  logic [LEN_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  entry_t              mem_q [DEPTH];

  logic                push, pop;
  logic [CNT_W-1:0]    count_next;

  // Redirect wins over both queue operations; only REQ can push because DROP
  // data belongs to a flushed instruction stream.
  assign pop        = (count_q != '0) && !bus.stall_i && !bus.redirect_i;
  assign push       = (state_q == REQ) && bus.imem_ack_i && !bus.redirect_i;
  assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_next;
    rptr_d     = rptr_q + PTR_W'(pop);
    wptr_d     = wptr_q + PTR_W'(push);

    if (push) fetch_pc_d = addr_q + LEN_ADDR'(1);

    if (bus.redirect_i) begin
      count_d    = '0;
      rptr_d     = '0;
      wptr_d     = '0;
      fetch_pc_d = bus.redirect_pc_i;
    end

    unique case (state_q)
      IDLE: begin
        // A redirect spends one cycle in IDLE so the new fetch_pc is in place
        // before the first request goes out.
        if (!bus.redirect_i && (count_next < DEPTH_C)) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (bus.redirect_i) begin
          if (bus.imem_ack_i) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            // Request stays on the bus unchanged; its data is dropped later.
            state_d = DROP;
          end
        end else if (bus.imem_ack_i) begin
          if (count_next < DEPTH_C) begin
            addr_d = addr_q + LEN_ADDR'(1);
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DROP: begin
        if (!bus.redirect_i && bus.imem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
    end
  end

  // NOTE: queue storage has no reset; count gates valid_o, so stale entries
  // are never visible and the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{pc: addr_q, insn: bus.imem_data_i};
  end

  assign bus.imem_req_o  = req_q;
  assign bus.imem_addr_o = addr_q;
  assign bus.valid_o     = (count_q != '0);
  assign bus.insn_o      = mem_q[rptr_q].insn;
  assign bus.pc_o        = mem_q[rptr_q].pc;

endmodule
